// File: rtl/cfu_popcount_initiator.sv
// ----------------------------------------------------------------------------
// cfu_popcount_initiator
//   Requester-side engine for a valid/ready level-1 CFU implementing
//   Popcount32. A host command supplies a word count; the engine pulls that
//   many words from a source stream, sends each one to the CFU as a single
//   request, and accumulates the returned counts into a running total.
//   Only one CFU request is ever outstanding.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   start, len          host command strobe and word count (IDLE only)
//   busy, done, err     status: busy outside IDLE, 1-cycle done, sticky err
//   total               accumulated popcount (modulo 2^TOTAL_W)
//   src_*               source stream (valid/ready/data)
//   req_*               CFU request channel (valid/ready/function id/data)
//   resp_*              CFU response channel (valid/ready/data)
// ----------------------------------------------------------------------------
module cfu_popcount_initiator #(
  parameter int CFU_FUNCTION_ID_W = 1,
  parameter int CFU_REQ_DATA_W    = 32,
  parameter int CFU_RESP_DATA_W   = 32,
  parameter int FUNC_ID           = 0,
  parameter int LEN_W             = 16,
  parameter int TOTAL_W           = 22,
  parameter int TIMEOUT           = 255
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [LEN_W-1:0]                       len,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   err,
  output logic [TOTAL_W-1:0]                     total,
  input  logic                                   src_valid,
  output logic                                   src_ready,
  input  logic [CFU_REQ_DATA_W-1:0]              src_data,
  output logic                                   req_valid,
  input  logic                                   req_ready,
  output logic [CFU_FUNCTION_ID_W-1:0]           req_function_id,
  output logic [0:0][CFU_REQ_DATA_W-1:0]         req_data,
  input  logic                                   resp_valid,
  output logic                                   resp_ready,
  input  logic [0:0][CFU_RESP_DATA_W-1:0]        resp_data
);

  // TIMEOUT is bounded to 16 bits, so the wait counter is sized to match.
  localparam int TMO_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_REQ,
    S_RESP,
    S_DONE
  } state_e;

  state_e                     state_q, state_d;
  logic [LEN_W-1:0]           cnt_q, cnt_d;
  logic [TMO_W-1:0]           tmo_q, tmo_d;
  logic [TOTAL_W-1:0]         total_q, total_d;
  logic                       err_q, err_d;
  logic [CFU_REQ_DATA_W-1:0]  data_q, data_d;
  logic                       busy_q, done_q, src_ready_q, req_valid_q, resp_ready_q;

  // Next-state and datapath. Handshakes are qualified by the state alone
  // because the ready/valid outputs are exactly registered state decodes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    total_d = total_q;
    err_d   = err_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          total_d = '0;
          err_d   = 1'b0;
          if (len != '0) begin
            cnt_d   = len;
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FETCH: begin
        if (src_valid) begin
          data_d  = src_data;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (req_ready) begin
          tmo_d   = '0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        // A response in the final allowed wait cycle still wins over abort.
        if (resp_valid) begin
          total_d = total_q + TOTAL_W'(resp_data[0]);
          cnt_d   = cnt_q - LEN_W'(1);
          state_d = (cnt_q == LEN_W'(1)) ? S_DONE : S_FETCH;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status and handshake outputs are registered from the next state so they
  // line up with the state they describe.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      tmo_q        <= '0;
      total_q      <= '0;
      err_q        <= 1'b0;
      data_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      src_ready_q  <= 1'b0;
      req_valid_q  <= 1'b0;
      resp_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      total_q      <= total_d;
      err_q        <= err_d;
      data_q       <= data_d;
      busy_q       <= (state_d != S_IDLE);
      done_q       <= (state_d == S_DONE);
      src_ready_q  <= (state_d == S_FETCH);
      req_valid_q  <= (state_d == S_REQ);
      resp_ready_q <= (state_d == S_RESP);
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign err             = err_q;
  assign total           = total_q;
  assign src_ready       = src_ready_q;
  assign req_valid       = req_valid_q;
  assign resp_ready      = resp_ready_q;
  assign req_data[0]     = data_q;
  assign req_function_id = CFU_FUNCTION_ID_W'(FUNC_ID);

endmodule

// File: doc/cfu_popcount_initiator.md
Name: cfu_popcount_initiator

Overview:
- Requester-side (initiator) engine for a level-1 (valid/ready handshaked) CFU that implements the Popcount32 function.
- Takes a host command (word count), pulls that many words from a source stream, and issues each word to the CFU as one request.
- Accepts each CFU response and accumulates the returned counts into a running total.
- Sits between a DMA/stream source and a popcount CFU; reports total, done and timeout error to the host.

Parameters:
- CFU_FUNCTION_ID_W, 1, width of req_function_id.
- CFU_REQ_DATA_W, 32, request data width.
- CFU_RESP_DATA_W, 32, response data width.
- FUNC_ID, 0, function id driven on every request (IID_Popcount32.Popcount32).
- LEN_W, 16, width of the word-count command.
- TOTAL_W, 22, accumulator width; must be >= clog2(CFU_REQ_DATA_W*(2^LEN_W-1)+1).
- TIMEOUT, 255, maximum cycles spent waiting in RESP before abort; range 1..65535.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  command strobe; sampled only in IDLE
- len  in  LEN_W  number of words to process; sampled with start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at completion or abort
- err  out  1  set on timeout; held until next accepted start
- total  out  TOTAL_W  accumulated popcount
- src_valid  in  1  source word available
- src_ready  out  1  source word accepted when src_valid && src_ready
- src_data  in  CFU_REQ_DATA_W  source word
- req_valid  out  1  CFU request valid
- req_ready  in  1  CFU accepts request
- req_function_id  out  CFU_FUNCTION_ID_W  always FUNC_ID
- req_data  out  [0:0] x CFU_REQ_DATA_W  request operand
- resp_valid  in  1  CFU response valid
- resp_ready  out  1  initiator accepts response
- resp_data  in  [0:0] x CFU_RESP_DATA_W  response result

Behaviour:
- Reset (synchronous, active-high; one clock, named clock; reset named reset): state=IDLE; busy, done, err, src_ready, req_valid, resp_ready = 0; total = 0; req_data = 0; word counter = 0; timeout counter = 0.
- Reset asserted mid-operation returns every register to its reset value on that edge. Any in-flight request or response is abandoned; the CFU side is expected to be reset with it.
- Only one request is ever outstanding.
- IDLE:
  - start=1 and len!=0: capture len into the counter, clear total and err, go to FETCH.
  - start=1 and len==0: clear total and err, go to DONE.
  - start=0: stay in IDLE.
- FETCH:
  - src_ready=1.
  - On src_valid: register src_data into req_data[0], go to REQ.
- REQ:
  - req_valid=1.
  - req_data and req_function_id are held stable while req_valid && !req_ready.
  - On req_ready: go to RESP and clear the timeout counter.
- RESP:
  - resp_ready=1.
  - On resp_valid: total <= total + resp_data[0][TOTAL_W-1:0], truncated modulo 2^TOTAL_W; decrement the word counter.
  - If the counter was 1, go to DONE; otherwise go to FETCH.
  - If no response arrives: increment the timeout counter. When it reaches TIMEOUT, set err=1 and go to DONE; total keeps the partial sum.
  - resp_valid in the same cycle the counter reaches TIMEOUT: the response wins, no error.
- DONE: done=1 for exactly one cycle, busy=1, then go to IDLE.
- start while busy=1 is ignored and not queued.
- total and err are stable from the DONE cycle until the next accepted start.
- Latency: 3 cycles per word minimum (FETCH, REQ, RESP each 1 cycle when the peer is ready). With start at cycle 0 and zero-wait peers, done rises at cycle 3*len+1. For len=0, done rises at cycle 1.
- src_valid/resp_valid outside their accepting states are ignored; src_ready/resp_ready are never asserted there.

Test Plan:
- start, len=3; words 0xFFFFFFFF, 0x00000001, 0xF0F0F0F0; zero-wait source and CFU model (response the cycle after request) -> total=49, done pulse at cycle 10, err=0, exactly 3 req handshakes.
- start, len=0 -> done at cycle 1, total=0, no src_ready/req_valid ever asserted.
- len=2; req_ready held low 5 cycles, src_valid gapped 3 cycles -> req_data/req_valid stable throughout stall, total = sum of popcounts, no lost/duplicated words.
- TIMEOUT=4; CFU never responds to the 2nd word -> err=1, done pulse, total = popcount of 1st word; next start clears err.
- Response arriving exactly on the timeout cycle -> accepted, err=0.
- reset asserted while in REQ -> next cycle all outputs at reset values, state IDLE; start pulsed during busy ignored.
